dp_ram_sync: RTL and testbench

//  Single-clock simple dual-port RAM (one write port, one read port) for buffering between pipeline stages.

---
 rtl/dp_ram_pkg.sv | 22 ++
 rtl/dp_ram_core.sv | 39 +++
 rtl/dp_ram_sync.sv | 224 ++++++++++++++++++++++
 tb/tb_dp_ram_sync.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_ram_pkg.sv
// Shared types and helpers for the dp_ram_sync RAM: FSM states, parity, read-latency limits.
package dp_ram_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;
  localparam int PAR_MAX_W  = 64;

  function automatic logic rd_lat_legal(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

  // Even-parity bit: data plus this bit always holds an even number of ones.
  function automatic logic even_par(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/dp_ram_core.sv
// Bare storage array for dp_ram_sync: one synchronous write port and one registered read port.
module dp_ram_core
  import dp_ram_pkg::*;
#(
  parameter int DW     = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DW-1:0]     wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DW-1:0]     rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Storage itself is never reset; clearing is done by the owner's init sweep.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= {DW{1'b0}};
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dp_ram_sync.sv
// Single-clock simple dual-port RAM with init sweep, write-first bypass and 1/2-cycle read latency.
// Optional per-word even parity with error injection is enabled by defining DP_RAM_PARITY_EN.
module dp_ram_sync
  import dp_ram_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 16,
  parameter int               ADDR_W   = 4,
  parameter int               RD_LAT   = 1,
  parameter logic [WIDTH-1:0] INIT_VAL = {WIDTH{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o,
  output logic              rd_valid_o,
  output logic              init_busy_o
`ifdef DP_RAM_PARITY_EN
  ,
  output logic              parity_err_o,
  input  logic              err_inj_i
`endif
);

`ifdef DP_RAM_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int                DW      = WIDTH + PW;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  if (!rd_lat_legal(RD_LAT)) begin : g_bad_lat
    $error("dp_ram_sync: RD_LAT must be 1 or 2");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q;

  logic              run_s, wr_in_range_s, rd_in_range_s;
  logic              wr_acc_s, rd_acc_s, byp_s;
  logic              core_we_s;
  logic [ADDR_W-1:0] core_waddr_s;
  logic [DW-1:0]     core_wdata_s, core_rdata_s;
  logic [DW-1:0]     user_word_s, init_word_s;

  logic              vld1_q, byp_q, oor_q;
  logic [WIDTH-1:0]  byp_data_q;
  logic [WIDTH-1:0]  s1_data_s;

  assign run_s         = (state_q == ST_RUN);
  assign wr_in_range_s = ({1'b0, wr_addr_i} < DEPTH_C);
  assign rd_in_range_s = ({1'b0, rd_addr_i} < DEPTH_C);
  assign wr_acc_s      = run_s & wr_en_i & wr_in_range_s;
  assign rd_acc_s      = run_s & rd_en_i;
  // An accepted write already implies an in-range address, so the read is in range too.
  assign byp_s         = wr_acc_s & rd_acc_s & (wr_addr_i == rd_addr_i);

`ifdef DP_RAM_PARITY_EN
  assign user_word_s = {even_par(PAR_MAX_W'(wr_data_i)) ^ err_inj_i, wr_data_i};
  assign init_word_s = {even_par(PAR_MAX_W'(INIT_VAL)), INIT_VAL};
`else
  assign user_word_s = wr_data_i;
  assign init_word_s = INIT_VAL;
`endif

  // Init FSM next state and sweep counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (clr_i) begin
          cnt_d = {ADDR_W{1'b0}};
        end else if (cnt_q == LAST_C) begin
          state_d = ST_RUN;
          cnt_d   = {ADDR_W{1'b0}};
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        if (clr_i) begin
          state_d = ST_INIT;
          cnt_d   = {ADDR_W{1'b0}};
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // FSM state, sweep counter and registered busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= {ADDR_W{1'b0}};
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == ST_INIT);
    end
  end

  // Write-port mux: the sweep owns the port outside RUN.
  always_comb begin
    core_we_s    = 1'b0;
    core_waddr_s = wr_addr_i;
    core_wdata_s = user_word_s;
    if (run_s) begin
      core_we_s    = wr_acc_s;
      core_waddr_s = wr_addr_i;
      core_wdata_s = user_word_s;
    end else begin
      core_we_s    = 1'b1;
      core_waddr_s = cnt_q;
      core_wdata_s = init_word_s;
    end
  end

  dp_ram_core #(
    .DW     (DW),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (core_we_s),
    .waddr_i (core_waddr_s),
    .wdata_i (core_wdata_s),
    .re_i    (rd_acc_s & rd_in_range_s & ~byp_s),
    .raddr_i (rd_addr_i),
    .rdata_o (core_rdata_s)
  );

  // First read stage: capture how the result must be sourced alongside the array read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_q     <= 1'b0;
      byp_q      <= 1'b0;
      oor_q      <= 1'b0;
      byp_data_q <= {WIDTH{1'b0}};
    end else begin
      vld1_q <= rd_acc_s;
      if (rd_acc_s) begin
        byp_q      <= byp_s;
        oor_q      <= ~rd_in_range_s;
        byp_data_q <= wr_data_i;
      end
    end
  end

  // Stage-1 result select; all sources only change on an accepted read, so the value holds.
  always_comb begin
    s1_data_s = core_rdata_s[WIDTH-1:0];
    if (byp_q) begin
      s1_data_s = byp_data_q;
    end else if (oor_q) begin
      s1_data_s = INIT_VAL;
    end else begin
      s1_data_s = core_rdata_s[WIDTH-1:0];
    end
  end

`ifdef DP_RAM_PARITY_EN
  logic s1_perr_s;
  assign s1_perr_s = vld1_q & ~byp_q & ~oor_q &
                     (even_par(PAR_MAX_W'(core_rdata_s[WIDTH-1:0])) ^ core_rdata_s[WIDTH]);
`endif

  if (RD_LAT == 2) begin : g_lat2
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;
`ifdef DP_RAM_PARITY_EN
    logic             perr_q;
`endif

    // Extra output register stage for the two-cycle latency build.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_q  <= {WIDTH{1'b0}};
        rd_valid_q <= 1'b0;
`ifdef DP_RAM_PARITY_EN
        perr_q     <= 1'b0;
`endif
      end else begin
        rd_valid_q <= vld1_q;
`ifdef DP_RAM_PARITY_EN
        perr_q     <= s1_perr_s;
`endif
        if (vld1_q) begin
          rd_data_q <= s1_data_s;
        end
      end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
`ifdef DP_RAM_PARITY_EN
    assign parity_err_o = perr_q;
`endif
  end else begin : g_lat1
    assign rd_data_o  = s1_data_s;
    assign rd_valid_o = vld1_q;
`ifdef DP_RAM_PARITY_EN
    assign parity_err_o = s1_perr_s;
`endif
  end

  assign init_busy_o = busy_q;

endmodule

// File: tb/tb_dp_ram_sync.sv
// Directed bench for dp_ram_sync: one RD_LAT=1 and one RD_LAT=2 instance share the same stimulus.
module tb_dp_ram_sync;

  logic       clk = 1'b0;
  logic       rst_n, clr, wr_en, rd_en;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data;
  logic [7:0] d1_data, d2_data;
  logic       d1_vld, d2_vld, d1_busy, d2_busy;
`ifdef DP_RAM_PARITY_EN
  logic       err_inj, d1_perr, d2_perr;
`endif
  int         checks = 0;
  int         errors = 0;
  logic [7:0] t4 [3];

  always #5 clk = ~clk;

  dp_ram_sync #(.WIDTH(8), .DEPTH(16), .ADDR_W(4), .RD_LAT(1), .INIT_VAL(8'h00)) u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (clr),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .rd_en_i     (rd_en),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (d1_data),
    .rd_valid_o  (d1_vld),
    .init_busy_o (d1_busy)
`ifdef DP_RAM_PARITY_EN
    ,
    .parity_err_o (d1_perr),
    .err_inj_i    (err_inj)
`endif
  );

  dp_ram_sync #(.WIDTH(8), .DEPTH(16), .ADDR_W(4), .RD_LAT(2), .INIT_VAL(8'h00)) u_dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (clr),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .rd_en_i     (rd_en),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (d2_data),
    .rd_valid_o  (d2_vld),
    .init_busy_o (d2_busy)
`ifdef DP_RAM_PARITY_EN
    ,
    .parity_err_o (d2_perr),
    .err_inj_i    (err_inj)
`endif
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = 4'd0; rd_addr = 4'd0; wr_data = 8'h00;
`ifdef DP_RAM_PARITY_EN
    err_inj = 1'b0;
`endif
    t4[0] = 8'h10; t4[1] = 8'h21; t4[2] = 8'h32;
    repeat (2) step();

    chk("rst_d1_data", 32'(d1_data), 32'h00);
    chk("rst_d1_vld", 32'(d1_vld), 32'h0);
    chk("rst_d1_busy", 32'(d1_busy), 32'h1);
    chk("rst_d2_data", 32'(d2_data), 32'h00);
    chk("rst_d2_vld", 32'(d2_vld), 32'h0);
    chk("rst_d2_busy", 32'(d2_busy), 32'h1);

    // Sweep after reset release; user traffic during it must be ignored.
    rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h77;
    rd_en = 1'b1; rd_addr = 4'd0;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("init_busy", 32'(d1_busy), (i < 16) ? 32'h1 : 32'h0);
      chk("init_busy2", 32'(d2_busy), (i < 16) ? 32'h1 : 32'h0);
      chk("init_vld1", 32'(d1_vld), 32'h0);
      chk("init_vld2", 32'(d2_vld), 32'h0);
    end
    wr_en = 1'b0; rd_en = 1'b0;

    // Test 1: every word reads back as INIT_VAL.
    for (int a = 0; a < 16; a++) begin
      rd_en = 1'b1; rd_addr = 4'(a);
      step();
      chk("t1_vld1", 32'(d1_vld), 32'h1);
      chk("t1_data1", 32'(d1_data), 32'h00);
      if (a > 0) begin
        chk("t1_vld2", 32'(d2_vld), 32'h1);
        chk("t1_data2", 32'(d2_data), 32'h00);
      end
    end
    rd_en = 1'b0;
    step();
    chk("t1_vld1_end", 32'(d1_vld), 32'h0);
    chk("t1_vld2_last", 32'(d2_vld), 32'h1);
    chk("t1_data2_last", 32'(d2_data), 32'h00);
    step();
    chk("t1_vld2_end", 32'(d2_vld), 32'h0);

    // Test 2: write then read, latency and single-cycle valid.
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5;
    step();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 4'd3;
    step();
    chk("t2_vld1", 32'(d1_vld), 32'h1);
    chk("t2_data1", 32'(d1_data), 32'hA5);
    chk("t2_vld2_early", 32'(d2_vld), 32'h0);
    rd_en = 1'b0;
    step();
    chk("t2_vld1_drop", 32'(d1_vld), 32'h0);
    chk("t2_data1_hold", 32'(d1_data), 32'hA5);
    chk("t2_vld2", 32'(d2_vld), 32'h1);
    chk("t2_data2", 32'(d2_data), 32'hA5);
    step();
    chk("t2_vld2_drop", 32'(d2_vld), 32'h0);
    chk("t2_data2_hold", 32'(d2_data), 32'hA5);

    // Test 3: write-first collision, then independent read/write.
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h11;
    step();
    wr_data = 8'h3C; rd_en = 1'b1; rd_addr = 4'd7;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("t3_coll_data1", 32'(d1_data), 32'h3C);
    chk("t3_coll_vld1", 32'(d1_vld), 32'h1);
    step();
    chk("t3_coll_data2", 32'(d2_data), 32'h3C);
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 8'h5A; rd_en = 1'b1; rd_addr = 4'd3;
    step();
    wr_en = 1'b0;
    chk("t3_indep_data1", 32'(d1_data), 32'hA5);
    rd_addr = 4'd9;
    step();
    chk("t3_indep_data2", 32'(d2_data), 32'hA5);
    chk("t3_rd9_data1", 32'(d1_data), 32'h5A);
    rd_addr = 4'd7;
    step();
    chk("t3_rd7_data1", 32'(d1_data), 32'h3C);
    rd_en = 1'b0;
    step();

    // Test 4: back-to-back reads.
    for (int k = 0; k < 3; k++) begin
      wr_en = 1'b1; wr_addr = 4'(k); wr_data = t4[k];
      step();
    end
    wr_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rd_en = (k < 3); rd_addr = 4'(k);
      step();
      if (k < 3) begin
        chk("t4_vld1", 32'(d1_vld), 32'h1);
        chk("t4_data1", 32'(d1_data), 32'(t4[k]));
      end else begin
        chk("t4_vld1_end", 32'(d1_vld), 32'h0);
      end
      if (k >= 1 && k <= 3) begin
        chk("t4_vld2", 32'(d2_vld), 32'h1);
        chk("t4_data2", 32'(d2_data), 32'(t4[k-1]));
      end else begin
        chk("t4_vld2_idle", 32'(d2_vld), 32'h0);
      end
    end
    rd_en = 1'b0;

    // Test 5: clear in RUN re-sweeps memory; the clr-cycle read is still served.
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'hFF;
    step();
    wr_en = 1'b0; clr = 1'b1; rd_en = 1'b1; rd_addr = 4'd5;
    step();
    clr = 1'b0;
    chk("t5_clr_vld1", 32'(d1_vld), 32'h1);
    chk("t5_clr_data1", 32'(d1_data), 32'hFF);
    chk("t5_clr_busy", 32'(d1_busy), 32'h1);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'hEE;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("t5_busy", 32'(d1_busy), (i < 16) ? 32'h1 : 32'h0);
      chk("t5_vld1", 32'(d1_vld), 32'h0);
      if (i == 1) begin
        chk("t5_clr_vld2", 32'(d2_vld), 32'h1);
        chk("t5_clr_data2", 32'(d2_data), 32'hFF);
      end else begin
        chk("t5_vld2", 32'(d2_vld), 32'h0);
      end
    end
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 4'd5;
    step();
    rd_en = 1'b0;
    chk("t5_after_vld1", 32'(d1_vld), 32'h1);
    chk("t5_after_data1", 32'(d1_data), 32'h00);
    step();
    chk("t5_after_data2", 32'(d2_data), 32'h00);

`ifdef DP_RAM_PARITY_EN
    // Test 6: injected parity error detected, cleared by a clean rewrite, never on bypass.
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h11; err_inj = 1'b1;
    step();
    wr_en = 1'b0; err_inj = 1'b0; rd_en = 1'b1; rd_addr = 4'd2;
    step();
    rd_en = 1'b0;
    chk("t6_perr1_bad", 32'(d1_perr), 32'h1);
    chk("t6_data1_bad", 32'(d1_data), 32'h11);
    step();
    chk("t6_perr2_bad", 32'(d2_perr), 32'h1);
    wr_en = 1'b1;
    step();
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("t6_perr1_good", 32'(d1_perr), 32'h0);
    step();
    chk("t6_perr2_good", 32'(d2_perr), 32'h0);
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 8'h22; err_inj = 1'b1; rd_en = 1'b1; rd_addr = 4'd4;
    step();
    wr_en = 1'b0; err_inj = 1'b0; rd_en = 1'b0;
    chk("t6_byp_perr1", 32'(d1_perr), 32'h0);
    chk("t6_byp_data1", 32'(d1_data), 32'h22);
`endif

    // Reset while a read is in flight drops its valid.
    rd_en = 1'b1; rd_addr = 4'd3;
    step();
    rd_en = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld2", 32'(d2_vld), 32'h0);
    chk("mid_rst_vld1", 32'(d1_vld), 32'h0);
    chk("mid_rst_data1", 32'(d1_data), 32'h00);
    chk("mid_rst_busy", 32'(d1_busy), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
